// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory bus port between IF and MEM, MEM first with an IF starvation guard and flush drop
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req_valid_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  input  logic                if_flush_i,
  output logic [DATA_W-1:0]   if_rdata_o,
  output logic                if_rvalid_o,
  input  logic                mem_req_valid_i,
  input  logic                mem_we_i,
  input  logic [ADDR_W-1:0]   mem_addr_i,
  input  logic [DATA_W-1:0]   mem_wdata_i,
  input  logic [DATA_W/8-1:0] mem_wstrb_i,
  input  logic [2:0]          mem_size_i,
  output logic [DATA_W-1:0]   mem_rdata_o,
  output logic                mem_rvalid_o,
  output logic                bus_req_valid_o,
  input  logic                bus_req_ready_i,
  output logic [ADDR_W-1:0]   bus_addr_o,
  output logic                bus_we_o,
  output logic [DATA_W-1:0]   bus_wdata_o,
  output logic [DATA_W/8-1:0] bus_wstrb_o,
  output logic [2:0]          bus_size_o,
  input  logic                bus_rsp_valid_i,
  input  logic [DATA_W-1:0]   bus_rdata_i,
  input  logic                bus_rsp_err_i,
  output logic                if_stall_o,
  output logic                mem_stall_o,
  output logic                err_o
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic owner_mem_q, owner_mem_d, drop_q, drop_d, err_q, err_d, we_q, we_d;
  logic [3:0] starve_q, starve_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
  logic [2:0] size_q, size_d;
  logic if_ok, starved, grant_if, grant_mem, capture;
  always_comb begin
    if_ok = if_req_valid_i & ~if_flush_i;
    starved = (starve_q == 4'(STARVE_MAX));
    grant_mem = (state_q == IDLE) & mem_req_valid_i & ~(if_ok & starved);
    grant_if = (state_q == IDLE) & if_ok & (~mem_req_valid_i | starved);
    capture = (state_q == WAIT) & bus_rsp_valid_i;
    state_d = (grant_mem | grant_if) ? REQ :
              ((state_q == REQ) & bus_req_ready_i) ? WAIT :
              capture ? RESP :
              (state_q == RESP) ? IDLE : state_q;
    owner_mem_d = grant_mem ? 1'b1 : grant_if ? 1'b0 : owner_mem_q;
    drop_d = (state_q == RESP) ? 1'b0 :
             drop_q | (if_flush_i & ~owner_mem_q & ((state_q == REQ) | (state_q == WAIT)));
    starve_d = (~if_req_valid_i | grant_if) ? 4'd0 :
               (grant_mem & ~starved) ? starve_q + 4'd1 : starve_q;
    addr_d = grant_mem ? mem_addr_i : grant_if ? if_addr_i : addr_q;
    we_d = grant_mem ? mem_we_i : grant_if ? 1'b0 : we_q;
    wdata_d = grant_mem ? mem_wdata_i : grant_if ? '0 : wdata_q;
    wstrb_d = grant_mem ? mem_wstrb_i : grant_if ? '0 : wstrb_q;
    size_d = grant_mem ? mem_size_i : grant_if ? 3'd2 : size_q;
    rdata_d = capture ? bus_rdata_i : rdata_q;
    err_d = capture ? bus_rsp_err_i : err_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_mem_q <= 1'b0;
      drop_q <= 1'b0;
      err_q <= 1'b0;
      starve_q <= '0;
      addr_q <= '0;
      we_q <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
      size_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_mem_q <= owner_mem_d;
      drop_q <= drop_d;
      err_q <= err_d;
      starve_q <= starve_d;
      addr_q <= addr_d;
      we_q <= we_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      size_q <= size_d;
      rdata_q <= rdata_d;
    end
  end
  assign bus_req_valid_o = (state_q == REQ);
  assign bus_addr_o = addr_q;
  assign bus_we_o = we_q;
  assign bus_wdata_o = wdata_q;
  assign bus_wstrb_o = wstrb_q;
  assign bus_size_o = size_q;
  assign mem_rvalid_o = (state_q == RESP) & owner_mem_q;
  assign if_rvalid_o = (state_q == RESP) & ~owner_mem_q & ~drop_q & ~if_flush_i;
  assign err_o = err_q & (mem_rvalid_o | if_rvalid_o);
  assign mem_stall_o = rst_n & mem_req_valid_i & ~mem_rvalid_o;
  assign if_stall_o = rst_n & if_req_valid_i & ~if_rvalid_o;
  assign if_rdata_o = rdata_q;
  assign mem_rdata_o = rdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scoreboard bench for the IF/MEM bus arbiter
module tb_mem_port_arbiter;
  typedef struct {bit is_mem; bit chk_data; logic [63:0] data; bit err;} exp_t;
  typedef struct {logic [31:0] addr; logic we; logic [7:0] wstrb; logic [2:0] size; logic [63:0] wdata;} log_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic if_req_valid_i, if_flush_i, if_rvalid_o, mem_req_valid_i, mem_we_i, mem_rvalid_o;
  logic [31:0] if_addr_i, mem_addr_i, bus_addr_o;
  logic [63:0] if_rdata_o, mem_wdata_i, mem_rdata_o, bus_wdata_o, bus_rdata_i;
  logic [7:0] mem_wstrb_i, bus_wstrb_o;
  logic [2:0] mem_size_i, bus_size_o;
  logic bus_req_valid_o, bus_req_ready_i, bus_we_o, bus_rsp_valid_i, bus_rsp_err_i;
  logic if_stall_o, mem_stall_o, err_o;
  int vectors = 0, miscompares = 0;
  int ready_dly = 0, rcnt = 0;
  bit auto_rsp = 1, rsp_err = 0, pend = 0;
  logic [31:0] pend_addr;
  exp_t exp_q[$];
  log_t log_q[$];
  always #5 clk = ~clk;
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(64), .STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid_i(if_req_valid_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
    .if_rdata_o(if_rdata_o), .if_rvalid_o(if_rvalid_o),
    .mem_req_valid_i(mem_req_valid_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
    .mem_wdata_i(mem_wdata_i), .mem_wstrb_i(mem_wstrb_i), .mem_size_i(mem_size_i),
    .mem_rdata_o(mem_rdata_o), .mem_rvalid_o(mem_rvalid_o),
    .bus_req_valid_o(bus_req_valid_o), .bus_req_ready_i(bus_req_ready_i),
    .bus_addr_o(bus_addr_o), .bus_we_o(bus_we_o), .bus_wdata_o(bus_wdata_o),
    .bus_wstrb_o(bus_wstrb_o), .bus_size_o(bus_size_o),
    .bus_rsp_valid_i(bus_rsp_valid_i), .bus_rdata_i(bus_rdata_i), .bus_rsp_err_i(bus_rsp_err_i),
    .if_stall_o(if_stall_o), .mem_stall_o(mem_stall_o), .err_o(err_o)
  );
  function automatic logic [63:0] rd_model(input logic [31:0] a);
    return {a ^ 32'h9122_3354, a ^ 32'hD566_7798};
  endfunction
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  function automatic void expect_rsp(input bit m, input bit cd, input logic [63:0] d, input bit e);
    exp_q.push_back('{m, cd, d, e});
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // bus slave model: ready after ready_dly REQ cycles, response the cycle after acceptance
  initial begin : responder
    bus_req_ready_i = 0;
    bus_rsp_valid_i = 0;
    bus_rdata_i = '0;
    bus_rsp_err_i = 0;
    forever begin
      tick();
      if (!auto_rsp) continue;
      bus_req_ready_i = 0;
      bus_rsp_valid_i = 0;
      if (!rst_n) begin
        rcnt = 0;
        pend = 0;
      end else if (bus_req_valid_o) begin
        if (rcnt >= ready_dly) begin
          bus_req_ready_i = 1;
          rcnt = 0;
          pend = 1;
          pend_addr = bus_addr_o;
          log_q.push_back('{bus_addr_o, bus_we_o, bus_wstrb_o, bus_size_o, bus_wdata_o});
        end else rcnt++;
      end else if (pend) begin
        bus_rsp_valid_i = 1;
        bus_rdata_i = rd_model(pend_addr);
        bus_rsp_err_i = rsp_err;
        pend = 0;
      end
    end
  end
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (if_rvalid_o || mem_rvalid_o) begin
        if (exp_q.size() == 0) chk("unexpected_rsp", {if_rvalid_o, mem_rvalid_o}, 0);
        else begin
          e = exp_q.pop_front();
          chk("rsp_port_mem", mem_rvalid_o, e.is_mem);
          chk("rsp_err", err_o, e.err);
          if (e.chk_data) chk("rsp_data", e.is_mem ? mem_rdata_o : if_rdata_o, e.data);
        end
      end
    end
  end
  task automatic mem_xact(input logic we, input logic [31:0] a, input logic [63:0] wd,
                          input logic [7:0] ws, input logic [2:0] sz);
    bit seen = 0;
    mem_req_valid_i = 1; mem_we_i = we; mem_addr_i = a;
    mem_wdata_i = wd; mem_wstrb_i = ws; mem_size_i = sz;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge clk);
      seen = mem_rvalid_o;
    end
    chk("mem_done", seen, 1);
    tick();
    mem_req_valid_i = 0;
  endtask
  task automatic if_xact(input logic [31:0] a);
    bit seen = 0, stall_ok = 1;
    if_req_valid_i = 1; if_addr_i = a;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge clk);
      seen = if_rvalid_o;
      if (!seen && !if_stall_o) stall_ok = 0;
    end
    chk("if_done", seen, 1);
    chk("if_stall_while_waiting", stall_ok, 1);
    chk("if_stall_in_rvalid", if_stall_o, 0);
    tick();
    if_req_valid_i = 0;
  endtask
  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin : stim
    int base, cnt_v, cnt_r;
    log_t l;
    if_req_valid_i = 0; if_flush_i = 0; if_addr_i = '0;
    mem_req_valid_i = 0; mem_we_i = 0; mem_addr_i = '0; mem_wdata_i = '0; mem_wstrb_i = '0; mem_size_i = '0;
    repeat (2) @(negedge clk);
    chk("rst_bus_valid", bus_req_valid_o, 0);
    chk("rst_bus_fields", {bus_addr_o, bus_we_o, bus_wstrb_o, bus_size_o}, 0);
    chk("rst_outputs", {if_rvalid_o, mem_rvalid_o, err_o, if_stall_o, mem_stall_o}, 0);
    tick();
    rst_n = 1;
    tick();
    // MEM read, minimum latency
    expect_rsp(1, 1, 64'h1122_3344_5566_7788, 0);
    mem_req_valid_i = 1; mem_we_i = 0; mem_addr_i = 32'h8000_0010; mem_size_i = 3'd3;
    @(negedge clk);
    chk("c0_mem_stall", mem_stall_o, 1);
    chk("c0_bus_valid", bus_req_valid_o, 0);
    @(negedge clk);
    chk("c1_bus_valid", bus_req_valid_o, 1);
    chk("c1_bus_addr", bus_addr_o, 32'h8000_0010);
    chk("c1_bus_size", bus_size_o, 3'd3);
    @(negedge clk);
    chk("c2_mem_stall", mem_stall_o, 1);
    chk("c2_rvalid", mem_rvalid_o, 0);
    @(negedge clk);
    chk("c3_mem_rvalid", mem_rvalid_o, 1);
    chk("c3_mem_stall", mem_stall_o, 0);
    tick();
    mem_req_valid_i = 0;
    tick();
    // IF and MEM in the same cycle: MEM wins
    base = log_q.size();
    expect_rsp(1, 1, rd_model(32'h0000_1000), 0);
    expect_rsp(0, 1, rd_model(32'h0000_0200), 0);
    fork
      mem_xact(0, 32'h0000_1000, '0, 8'hFF, 3'd3);
      if_xact(32'h0000_0200);
    join
    chk("tie_first_mem", log_q[base].addr, 32'h0000_1000);
    l = log_q[base + 1];
    chk("tie_second_if", l.addr, 32'h0000_0200);
    chk("if_fields", {l.we, l.wstrb, l.size}, {1'b0, 8'h00, 3'd2});
    tick();
    // starvation guard: 4 MEM grants, then IF
    base = log_q.size();
    for (int i = 0; i < 4; i++) expect_rsp(1, 1, rd_model(32'h0000_3000 + 32'(i * 8)), 0);
    expect_rsp(0, 1, rd_model(32'h0000_0400), 0);
    expect_rsp(1, 1, rd_model(32'h0000_3020), 0);
    fork
      if_xact(32'h0000_0400);
      for (int i = 0; i < 5; i++) mem_xact(0, 32'h0000_3000 + 32'(i * 8), '0, 8'hFF, 3'd3);
    join
    chk("starve_grants", log_q.size() - base, 6);
    for (int i = 0; i < 4; i++) chk("starve_mem_order", log_q[base + i].addr, 32'h0000_3000 + 32'(i * 8));
    chk("starve_if_5th", log_q[base + 4].addr, 32'h0000_0400);
    chk("starve_mem_after", log_q[base + 5].addr, 32'h0000_3020);
    tick();
    // IF flushed in REQ while ready is held low
    ready_dly = 3;
    if_req_valid_i = 1; if_addr_i = 32'h0000_0500;
    tick();
    if_flush_i = 1; if_req_valid_i = 0;
    cnt_v = 0; cnt_r = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (bus_req_valid_o) begin
        cnt_v++;
        chk("flush_addr_held", bus_addr_o, 32'h0000_0500);
      end
      if (if_rvalid_o) cnt_r++;
      tick();
      if_flush_i = 0;
    end
    chk("flush_req_cycles", cnt_v, 4);
    chk("flush_no_rvalid", cnt_r, 0);
    ready_dly = 0;
    // FSM back in IDLE: a MEM write with error completes
    rsp_err = 1;
    expect_rsp(1, 0, '0, 1);
    mem_xact(1, 32'h0000_6000, 64'hDEAD_BEEF_0BAD_F00D, 8'h0F, 3'd2);
    l = log_q[log_q.size() - 1];
    chk("wr_fields", {l.addr, l.we, l.wstrb}, {32'h0000_6000, 1'b1, 8'h0F});
    chk("wr_wdata", l.wdata, 64'hDEAD_BEEF_0BAD_F00D);
    rsp_err = 0;
    tick();
    // flush together with IF request in IDLE: no grant
    if_req_valid_i = 1; if_flush_i = 1; if_addr_i = 32'h0000_0700;
    tick();
    if_req_valid_i = 0; if_flush_i = 0;
    @(negedge clk);
    chk("flush_blocks_grant", bus_req_valid_o, 0);
    tick();
    // flush in the RESP cycle of IF suppresses the response
    if_req_valid_i = 1; if_addr_i = 32'h0000_0800;
    repeat (3) tick();
    if_flush_i = 1; if_req_valid_i = 0;
    @(negedge clk);
    chk("flush_in_resp", {if_rvalid_o, err_o}, 0);
    chk("resp_reached", log_q[log_q.size() - 1].addr, 32'h0000_0800);
    tick();
    if_flush_i = 0;
    tick();
    // async reset while in WAIT
    auto_rsp = 0;
    tick();
    mem_req_valid_i = 1; mem_we_i = 0; mem_addr_i = 32'h0000_9000;
    tick();
    bus_req_ready_i = 1;
    tick();
    bus_req_ready_i = 0;
    @(negedge clk);
    chk("wait_state", {bus_req_valid_o, mem_stall_o}, 2'b01);
    tick();
    rst_n = 0;
    #1;
    chk("async_rst_out", {bus_req_valid_o, mem_rvalid_o, if_rvalid_o, err_o, mem_stall_o, bus_addr_o}, 0);
    mem_req_valid_i = 0;
    repeat (2) tick();
    rst_n = 1;
    bus_rsp_valid_i = 1; bus_rdata_i = 64'h5555_AAAA_5555_AAAA;
    tick();
    bus_rsp_valid_i = 0;
    cnt_r = 0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      if (if_rvalid_o || mem_rvalid_o) cnt_r++;
    end
    chk("late_rsp_ignored", cnt_r, 0);
    auto_rsp = 1;
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single core-side memory bus port between instruction fetch (IF) and load/store (MEM) requesters.
- Sequences each transaction through request/response handshakes, and registers the request fields so the bus sees them stable.
- Generates the IF and MEM RAM-stall requests consumed by pipeline control.
- Prioritises MEM (later stage) over IF, with a starvation guard for IF; drops IF responses killed by a pipeline flush.

Parameters:
ADDR_W, 32, address width
DATA_W, 64, data width (multiple of 8)
STARVE_MAX, 4, consecutive MEM grants while IF waits before IF is forced a grant (1..15)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
if_req_valid_i  in  1  IF read request, held until if_rvalid_o
if_addr_i  in  ADDR_W  IF address
if_flush_i  in  1  IF flush (jump/trap); kills the outstanding IF request
if_rdata_o  out  DATA_W  IF read data
if_rvalid_o  out  1  IF response pulse
mem_req_valid_i  in  1  MEM request, held until mem_rvalid_o
mem_we_i  in  1  1=write
mem_addr_i  in  ADDR_W  MEM address
mem_wdata_i  in  DATA_W  write data
mem_wstrb_i  in  DATA_W/8  byte strobes
mem_size_i  in  3  log2 bytes
mem_rdata_o  out  DATA_W  MEM read data
mem_rvalid_o  out  1  MEM response pulse
bus_req_valid_o  out  1  bus request valid
bus_req_ready_i  in  1  bus request accepted
bus_addr_o  out  ADDR_W  registered address
bus_we_o  out  1  registered write enable
bus_wdata_o  out  DATA_W  registered write data
bus_wstrb_o  out  DATA_W/8  registered strobes (0 for IF)
bus_size_o  out  3  registered size (IF = 3'd2)
bus_rsp_valid_i  in  1  bus response valid
bus_rdata_i  in  DATA_W  bus read data
bus_rsp_err_i  in  1  bus error with response
if_stall_o  out  1  to pipeline control: ram_stall_valid_if
mem_stall_o  out  1  to pipeline control: ram_stall_valid_mem
err_o  out  1  one-cycle pulse with an errored delivered response

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; drop flag, owner and starve counter cleared.
  - All outputs 0, bus_* fields 0.
  - Reset mid-transaction abandons it; no response is delivered.
- FSM states: IDLE, REQ, WAIT, RESP. An owner register (IF/MEM) is latched at grant.
- IDLE arbitration:
  - Grant MEM if mem_req_valid_i and not forced.
  - Grant IF if if_req_valid_i and not if_flush_i, and (no MEM request, or starve counter == STARVE_MAX).
  - On grant: latch bus_* fields from the winner; go to REQ.
- REQ:
  - bus_req_valid_o=1; fields held constant.
  - On bus_req_ready_i go to WAIT. Valid is never withdrawn before ready.
- WAIT: on bus_rsp_valid_i, capture bus_rdata_i and bus_rsp_err_i; go to RESP.
- RESP (1 cycle):
  - Owner MEM: mem_rvalid_o=1.
  - Owner IF: if_rvalid_o=1 unless drop flag or if_flush_i is set this cycle.
  - err_o = captured err, only when a response is delivered.
  - Next state IDLE.
  - Minimum latency: grant cycle 0, ready cycle 1, response cycle 2, rvalid cycle 3.
- Drop flag:
  - Set when if_flush_i=1 while owner=IF in REQ or WAIT.
  - The transaction still completes on the bus; its response is discarded.
  - Cleared on leaving RESP.
- Read data outputs hold their last captured value; they are valid only with rvalid.
- Starve counter:
  - Increments on each MEM grant while if_req_valid_i=1, saturating at STARVE_MAX.
  - Clears on IF grant or when if_req_valid_i=0.
- Stalls (combinational):
  - mem_stall_o = mem_req_valid_i & ~mem_rvalid_o.
  - if_stall_o = if_req_valid_i & ~if_rvalid_o.
  - Both deassert in the rvalid cycle.
- Simultaneous events:
  - Flush and grant in the same IDLE cycle: IF is not granted.
  - Flush in the RESP cycle of IF: the response is suppressed.
  - A new request is arbitrated only in IDLE, so there are no back-to-back grants within RESP.
- Writes return a response like reads; mem_rdata_o is don't-care for writes.

Test Plan:
- MEM read, addr 0x8000_0010, ready and rsp immediate, rdata 0x1122_3344_5566_7788 -> bus_req_valid_o in cycle 1; mem_rvalid_o=1 with that data in cycle 3; mem_stall_o high cycles 0-2.
- IF and MEM request in the same cycle -> MEM granted first; IF granted at the following IDLE; if_stall_o high until IF's rvalid.
- MEM requests continuously with IF pending, STARVE_MAX=4 -> after 4 MEM grants, the 5th grant goes to IF; counter clears.
- IF owns the bus, bus_req_ready_i low 3 cycles, if_flush_i pulsed in REQ -> bus_req_valid_o held until ready; response consumed; no if_rvalid_o; FSM returns to IDLE.
- MEM write with bus_rsp_err_i=1, wstrb 0x0F -> bus_wstrb_o=0x0F, bus_we_o=1; mem_rvalid_o and err_o pulse together.
- rst_n dropped while in WAIT -> outputs 0 immediately; late bus_rsp_valid_i after reset release produces no rvalid.
